// File: rtl/csa_tree_acc_pipe_if.sv
// Beat/result bundle for csa_tree_acc_pipe: operand beat with group flags in, carry-save result out.
interface csa_tree_acc_pipe_if #(
    parameter int NUM_IN = 66,
    parameter int WIDTH  = 23,
    parameter int CNT_W  = 8
);
    logic                         in_valid;
    logic                         in_first;
    logic                         in_last;
    logic                         acc_mode;
    logic [NUM_IN-1:0][WIDTH-1:0] in_data;

    logic                         out_valid;
    logic [WIDTH-1:0]             out_c;
    logic [WIDTH-1:0]             out_s;
    logic [CNT_W-1:0]             out_beats;
    logic                         err_restart;

    modport master (
        output in_valid, in_first, in_last, acc_mode, in_data,
        input  out_valid, out_c, out_s, out_beats, err_restart
    );

    modport slave (
        input  in_valid, in_first, in_last, acc_mode, in_data,
        output out_valid, out_c, out_s, out_beats, err_restart
    );
endinterface

// File: rtl/csa_tree_acc_pipe.sv
// Pipelined 3:2 CSA tree reducing NUM_IN operands to a carry/sum pair, merged with a carry-save group accumulator.
// Latency ceil((L+2)/LPS) cycles, one beat per cycle with no bubbles.
// No backpressure: every valid beat is accepted and its result is presented as a one-cycle pulse.
module csa_tree_acc_pipe #(
    parameter int NUM_IN = 66,
    parameter int WIDTH  = 23,
    parameter int LPS    = 4,
    parameter int CNT_W  = 8
) (
    input  logic               clk_sq,
    input  logic               reset_sq,
    csa_tree_acc_pipe_if.slave bus
);

    function automatic int lvl_cnt(input int lvl);
        int n = NUM_IN;
        for (int i = 0; i < lvl; i++) begin
            n = 2 * (n / 3) + n % 3;
        end
        return n;
    endfunction

    function automatic int num_levels();
        int n = NUM_IN;
        int k = 0;
        while (n > 2) begin
            n = 2 * (n / 3) + n % 3;
            k++;
        end
        return k;
    endfunction

    function automatic logic [WIDTH-1:0] csa_s(input logic [WIDTH-1:0] a, b, c);
        return a ^ b ^ c;
    endfunction

    // Carry is weighted one bit up; the bit shifted past the MSB is dropped (mod 2^WIDTH).
    function automatic logic [WIDTH-1:0] csa_c(input logic [WIDTH-1:0] a, b, c);
        return ((a & b) | (a & c) | (b & c)) << 1;
    endfunction

    localparam int L    = num_levels();
    // Level boundaries p = LPS, 2*LPS, ... up to L+1 carry a register; the output register follows level L+2.
    localparam int NCUT = (L + 1) / LPS;

    typedef struct packed {
        logic vld;
        logic first;
        logic last;
        logic mode;
    } flag_t;

    for (genvar l = 0; l <= L; l++) begin : gen_lvl
        localparam int N = lvl_cnt(l);
        logic [WIDTH-1:0] v [N];

        if (l == 0) begin : g_src
            for (genvar k = 0; k < NUM_IN; k++) begin : g_op
                assign v[k] = bus.in_data[k];
            end
        end else begin : g_csa
            localparam int NP = lvl_cnt(l - 1);
            localparam int NG = NP / 3;
            logic [WIDTH-1:0] v_d [N];

            always_comb begin
                for (int g = 0; g < NG; g++) begin
                    v_d[2*g]   = csa_s(gen_lvl[l-1].v[3*g], gen_lvl[l-1].v[3*g+1], gen_lvl[l-1].v[3*g+2]);
                    v_d[2*g+1] = csa_c(gen_lvl[l-1].v[3*g], gen_lvl[l-1].v[3*g+1], gen_lvl[l-1].v[3*g+2]);
                end
                for (int r = 0; r < NP % 3; r++) begin
                    v_d[2*NG+r] = gen_lvl[l-1].v[3*NG+r];
                end
            end

            if (l % LPS == 0) begin : g_reg
                logic [WIDTH-1:0] v_q [N];
                always_ff @(posedge clk_sq) begin
                    v_q <= v_d;
                end
                assign v = v_q;
            end else begin : g_wire
                assign v = v_d;
            end
        end
    end

    // A cut landing inside the 4:2 merge is realised as a plain delay of the tree pair,
    // so the accumulator feedback always closes within the output segment.
    logic [WIDTH-1:0] pr [2];
    if ((L + 1) % LPS == 0) begin : g_pair_reg
        logic [WIDTH-1:0] pr_q [2];
        always_ff @(posedge clk_sq) begin
            pr_q <= gen_lvl[L].v;
        end
        assign pr = pr_q;
    end else begin : g_pair_wire
        assign pr = gen_lvl[L].v;
    end

    flag_t fl_d;
    flag_t fin;
    assign fl_d = {bus.in_valid, bus.in_first, bus.in_last, bus.acc_mode};

    if (NCUT == 0) begin : g_fl_wire
        assign fin = fl_d;
    end else begin : g_fl_pipe
        flag_t fl_q [NCUT];
        always_ff @(posedge clk_sq) begin
            if (reset_sq) begin
                for (int i = 0; i < NCUT; i++) begin
                    fl_q[i] <= '0;
                end
            end else begin
                fl_q[0] <= fl_d;
                for (int i = 1; i < NCUT; i++) begin
                    fl_q[i] <= fl_q[i-1];
                end
            end
        end
        assign fin = fl_q[NCUT-1];
    end

    logic [WIDTH-1:0] acc_c_q, acc_c_d;
    logic [WIDTH-1:0] acc_s_q, acc_s_d;
    logic [CNT_W-1:0] beat_cnt_q, beat_cnt_d;
    logic             grp_open_q, grp_open_d;
    logic             err_q, err_d;
    logic             out_valid_q, out_valid_d;
    logic [WIDTH-1:0] out_c_q, out_c_d;
    logic [WIDTH-1:0] out_s_q, out_s_d;
    logic [CNT_W-1:0] out_beats_q, out_beats_d;

    logic             use_acc;
    logic [WIDTH-1:0] a_c, a_s;
    logic [WIDTH-1:0] m1_s, m1_c, m_s, m_c;
    logic [CNT_W-1:0] cnt_base, cnt_inc;

    always_comb begin
        use_acc  = fin.mode && !fin.first && grp_open_q;
        a_c      = use_acc ? acc_c_q : '0;
        a_s      = use_acc ? acc_s_q : '0;
        m1_s     = csa_s(pr[0], pr[1], a_c);
        m1_c     = csa_c(pr[0], pr[1], a_c);
        m_s      = csa_s(m1_s, m1_c, a_s);
        m_c      = csa_c(m1_s, m1_c, a_s);
        cnt_base = (fin.first || !grp_open_q) ? '0 : beat_cnt_q;
        cnt_inc  = (&cnt_base) ? cnt_base : cnt_base + 1'b1;

        acc_c_d     = acc_c_q;
        acc_s_d     = acc_s_q;
        beat_cnt_d  = beat_cnt_q;
        grp_open_d  = grp_open_q;
        err_d       = err_q;
        out_valid_d = 1'b0;
        out_c_d     = out_c_q;
        out_s_d     = out_s_q;
        out_beats_d = out_beats_q;

        if (fin.vld) begin
            if (!fin.mode) begin
                // Independent beat; any open group is left as it is.
                out_valid_d = 1'b1;
                out_c_d     = m_c;
                out_s_d     = m_s;
                out_beats_d = CNT_W'(1);
            end else begin
                if (fin.first && grp_open_q) begin
                    err_d = 1'b1;
                end
                if (fin.last) begin
                    out_valid_d = 1'b1;
                    out_c_d     = m_c;
                    out_s_d     = m_s;
                    out_beats_d = cnt_inc;
                    acc_c_d     = '0;
                    acc_s_d     = '0;
                    beat_cnt_d  = '0;
                    grp_open_d  = 1'b0;
                end else begin
                    acc_c_d     = m_c;
                    acc_s_d     = m_s;
                    beat_cnt_d  = cnt_inc;
                    grp_open_d  = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk_sq) begin
        if (reset_sq) begin
            acc_c_q     <= '0;
            acc_s_q     <= '0;
            beat_cnt_q  <= '0;
            grp_open_q  <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            out_c_q     <= '0;
            out_s_q     <= '0;
            out_beats_q <= '0;
        end else begin
            acc_c_q     <= acc_c_d;
            acc_s_q     <= acc_s_d;
            beat_cnt_q  <= beat_cnt_d;
            grp_open_q  <= grp_open_d;
            err_q       <= err_d;
            out_valid_q <= out_valid_d;
            out_c_q     <= out_c_d;
            out_s_q     <= out_s_d;
            out_beats_q <= out_beats_d;
        end
    end

    assign bus.out_valid   = out_valid_q;
    assign bus.out_c       = out_c_q;
    assign bus.out_s       = out_s_q;
    assign bus.out_beats   = out_beats_q;
    assign bus.err_restart = err_q;

endmodule

// File: tb/tb_csa_tree_acc_pipe.sv
// Directed bench for csa_tree_acc_pipe: default 66x23 instance and a 3x8 LPS=1 instance with a 2-bit beat counter.
module tb_csa_tree_acc_pipe;
    localparam int NI = 66;
    localparam int W  = 23;
    localparam int CW = 8;

    logic clk_sq = 1'b0;
    logic reset_sq;
    always #5 clk_sq = ~clk_sq;

    csa_tree_acc_pipe_if #(.NUM_IN(NI), .WIDTH(W), .CNT_W(CW)) bus_d ();
    csa_tree_acc_pipe_if #(.NUM_IN(3), .WIDTH(8), .CNT_W(2)) bus_s ();

    csa_tree_acc_pipe #(.NUM_IN(NI), .WIDTH(W), .LPS(4), .CNT_W(CW)) u_dut (
        .clk_sq   (clk_sq),
        .reset_sq (reset_sq),
        .bus      (bus_d.slave)
    );

    csa_tree_acc_pipe #(.NUM_IN(3), .WIDTH(8), .LPS(1), .CNT_W(2)) u_small (
        .clk_sq   (clk_sq),
        .reset_sq (reset_sq),
        .bus      (bus_s.slave)
    );

    int n_vec = 0;
    int n_err = 0;
    int cyc   = 0;

    always @(posedge clk_sq) cyc <= cyc + 1;

    typedef struct {
        logic [W-1:0]  sum;
        logic [CW-1:0] beats;
        int            cyc;
    } res_d_t;

    typedef struct {
        logic [7:0] sum;
        logic [1:0] beats;
        int         cyc;
    } res_s_t;

    res_d_t rq_d[$];
    res_s_t rq_s[$];

    always @(negedge clk_sq) begin : mon_d
        res_d_t r;
        if (bus_d.out_valid === 1'b1) begin
            r.sum   = bus_d.out_c + bus_d.out_s;
            r.beats = bus_d.out_beats;
            r.cyc   = cyc;
            rq_d.push_back(r);
        end
    end

    always @(negedge clk_sq) begin : mon_s
        res_s_t r;
        if (bus_s.out_valid === 1'b1) begin
            r.sum   = bus_s.out_c + bus_s.out_s;
            r.beats = bus_s.out_beats;
            r.cyc   = cyc;
            rq_s.push_back(r);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk_sq);
        #1;
    endtask

    function automatic logic [NI-1:0][W-1:0] all_d(input logic [W-1:0] val);
        logic [NI-1:0][W-1:0] r;
        for (int k = 0; k < NI; k++) r[k] = val;
        return r;
    endfunction

    task automatic idle_d();
        bus_d.in_valid = 1'b0;
        bus_d.in_first = 1'b0;
        bus_d.in_last  = 1'b0;
        bus_d.acc_mode = 1'b0;
    endtask

    task automatic idle_s();
        bus_s.in_valid = 1'b0;
        bus_s.in_first = 1'b0;
        bus_s.in_last  = 1'b0;
        bus_s.acc_mode = 1'b0;
    endtask

    task automatic beat_d(input logic f, input logic l, input logic m, input logic [NI-1:0][W-1:0] data);
        bus_d.in_valid = 1'b1;
        bus_d.in_first = f;
        bus_d.in_last  = l;
        bus_d.acc_mode = m;
        bus_d.in_data  = data;
        tick(1);
    endtask

    task automatic beat_s(input logic f, input logic l, input logic m, input logic [7:0] o2, o1, o0);
        bus_s.in_valid   = 1'b1;
        bus_s.in_first   = f;
        bus_s.in_last    = l;
        bus_s.acc_mode   = m;
        bus_s.in_data[2] = o2;
        bus_s.in_data[1] = o1;
        bus_s.in_data[0] = o0;
        tick(1);
    endtask

    task automatic test_reset();
        reset_sq = 1'b1;
        idle_d();
        idle_s();
        bus_d.in_data = '0;
        bus_s.in_data = '0;
        tick(2);
        n_vec++; if (bus_d.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid: got %b want 0", bus_d.out_valid); end
        n_vec++; if (bus_d.out_c !== 23'h0) begin n_err++; $display("FAIL reset_out_c: got %h want 0", bus_d.out_c); end
        n_vec++; if (bus_d.out_s !== 23'h0) begin n_err++; $display("FAIL reset_out_s: got %h want 0", bus_d.out_s); end
        n_vec++; if (bus_d.out_beats !== 8'h0) begin n_err++; $display("FAIL reset_out_beats: got %0d want 0", bus_d.out_beats); end
        n_vec++; if (bus_d.err_restart !== 1'b0) begin n_err++; $display("FAIL reset_err_restart: got %b want 0", bus_d.err_restart); end
        n_vec++; if (bus_s.out_valid !== 1'b0) begin n_err++; $display("FAIL reset_small_valid: got %b want 0", bus_s.out_valid); end
        reset_sq = 1'b0;
        tick(1);
    endtask

    task automatic test_all_ones();
        int t0;
        logic [W-1:0] held;
        rq_d.delete();
        t0 = cyc;
        beat_d(1'b0, 1'b0, 1'b0, all_d(23'h7FFFFF));
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 1) begin
            n_err++; $display("FAIL ones_count: got %0d results want 1", rq_d.size());
        end else begin
            n_vec++; if (rq_d[0].sum !== 23'h7FFFBE) begin n_err++; $display("FAIL ones_sum: got %h want 7fffbe", rq_d[0].sum); end
            n_vec++; if (rq_d[0].beats !== 8'd1) begin n_err++; $display("FAIL ones_beats: got %0d want 1", rq_d[0].beats); end
            n_vec++; if (rq_d[0].cyc - t0 != 3) begin n_err++; $display("FAIL ones_latency: got %0d want 3", rq_d[0].cyc - t0); end
        end
        held = bus_d.out_c + bus_d.out_s;
        n_vec++; if (bus_d.out_valid !== 1'b0) begin n_err++; $display("FAIL ones_pulse: got %b want 0", bus_d.out_valid); end
        n_vec++; if (held !== 23'h7FFFBE) begin n_err++; $display("FAIL ones_hold: got %h want 7fffbe", held); end
    endtask

    task automatic test_back_to_back();
        int t0;
        logic [NI-1:0][W-1:0] v;
        logic [W-1:0] exp_q[$];
        logic [W-1:0] s;
        rq_d.delete();
        t0 = cyc;
        for (int i = 0; i < 100; i++) begin
            s = '0;
            for (int k = 0; k < NI; k++) begin
                v[k] = W'($urandom);
                s    = s + v[k];
            end
            exp_q.push_back(s);
            beat_d(1'b0, 1'b0, 1'b0, v);
        end
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 100) begin
            n_err++; $display("FAIL b2b_count: got %0d results want 100", rq_d.size());
        end else begin
            for (int i = 0; i < 100; i++) begin
                n_vec++;
                if (rq_d[i].sum !== exp_q[i] || rq_d[i].cyc != t0 + 3 + i) begin
                    n_err++;
                    $display("FAIL b2b_%0d: got sum %h at cycle %0d want %h at %0d", i, rq_d[i].sum, rq_d[i].cyc, exp_q[i], t0 + 3 + i);
                end
            end
        end
    endtask

    task automatic test_accumulate();
        logic [NI-1:0][W-1:0] v;
        for (int k = 0; k < NI; k++) v[k] = W'(k);
        rq_d.delete();
        beat_d(1'b1, 1'b0, 1'b1, v);
        beat_d(1'b0, 1'b0, 1'b1, v);
        beat_d(1'b0, 1'b0, 1'b1, v);
        beat_d(1'b0, 1'b1, 1'b1, v);
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 1) begin
            n_err++; $display("FAIL acc_count: got %0d results want 1", rq_d.size());
        end else begin
            n_vec++; if (rq_d[0].sum !== 23'd8580) begin n_err++; $display("FAIL acc_sum: got %0d want 8580", rq_d[0].sum); end
            n_vec++; if (rq_d[0].beats !== 8'd4) begin n_err++; $display("FAIL acc_beats: got %0d want 4", rq_d[0].beats); end
        end
    endtask

    task automatic test_interleave();
        rq_d.delete();
        beat_d(1'b1, 1'b0, 1'b1, all_d(23'd1));
        beat_d(1'b0, 1'b0, 1'b0, all_d(23'd7));
        beat_d(1'b0, 1'b1, 1'b1, all_d(23'd2));
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 2) begin
            n_err++; $display("FAIL ilv_count: got %0d results want 2", rq_d.size());
        end else begin
            n_vec++; if (rq_d[0].sum !== 23'd462 || rq_d[0].beats !== 8'd1) begin n_err++; $display("FAIL ilv_indep: got %0d/%0d want 462/1", rq_d[0].sum, rq_d[0].beats); end
            n_vec++; if (rq_d[1].sum !== 23'd198 || rq_d[1].beats !== 8'd2) begin n_err++; $display("FAIL ilv_group: got %0d/%0d want 198/2", rq_d[1].sum, rq_d[1].beats); end
        end
        n_vec++; if (bus_d.err_restart !== 1'b0) begin n_err++; $display("FAIL ilv_err: got %b want 0", bus_d.err_restart); end
    endtask

    task automatic test_restart();
        rq_d.delete();
        beat_d(1'b1, 1'b0, 1'b1, all_d(23'd1));
        beat_d(1'b0, 1'b0, 1'b1, all_d(23'd1));
        beat_d(1'b1, 1'b0, 1'b1, all_d(23'd2));
        beat_d(1'b0, 1'b1, 1'b1, all_d(23'd3));
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 1) begin
            n_err++; $display("FAIL rst_grp_count: got %0d results want 1", rq_d.size());
        end else begin
            n_vec++; if (rq_d[0].sum !== 23'd330) begin n_err++; $display("FAIL restart_sum: got %0d want 330", rq_d[0].sum); end
            n_vec++; if (rq_d[0].beats !== 8'd2) begin n_err++; $display("FAIL restart_beats: got %0d want 2", rq_d[0].beats); end
        end
        n_vec++; if (bus_d.err_restart !== 1'b1) begin n_err++; $display("FAIL restart_err: got %b want 1", bus_d.err_restart); end
    endtask

    task automatic test_reset_mid();
        rq_d.delete();
        beat_d(1'b1, 1'b0, 1'b1, all_d(23'd4));
        beat_d(1'b0, 1'b0, 1'b1, all_d(23'd4));
        beat_d(1'b0, 1'b1, 1'b1, all_d(23'd4));
        idle_d();
        reset_sq = 1'b1;
        tick(1);
        reset_sq = 1'b0;
        n_vec++; if (bus_d.out_valid !== 1'b0) begin n_err++; $display("FAIL midrst_valid: got %b want 0", bus_d.out_valid); end
        tick(6);
        n_vec++; if (rq_d.size() != 0) begin n_err++; $display("FAIL midrst_drop: got %0d results want 0", rq_d.size()); end
        n_vec++; if (bus_d.err_restart !== 1'b0) begin n_err++; $display("FAIL midrst_err: got %b want 0", bus_d.err_restart); end
        rq_d.delete();
        beat_d(1'b1, 1'b1, 1'b1, all_d(23'd5));
        idle_d();
        tick(6);
        n_vec++;
        if (rq_d.size() != 1) begin
            n_err++; $display("FAIL single_count: got %0d results want 1", rq_d.size());
        end else begin
            n_vec++; if (rq_d[0].sum !== 23'd330) begin n_err++; $display("FAIL single_sum: got %0d want 330", rq_d[0].sum); end
            n_vec++; if (rq_d[0].beats !== 8'd1) begin n_err++; $display("FAIL single_beats: got %0d want 1", rq_d[0].beats); end
        end
    endtask

    task automatic test_small();
        int t0;
        rq_s.delete();
        t0 = cyc;
        beat_s(1'b0, 1'b0, 1'b0, 8'h02, 8'hFF, 8'hFF);
        idle_s();
        tick(6);
        n_vec++;
        if (rq_s.size() != 1) begin
            n_err++; $display("FAIL small_count: got %0d results want 1", rq_s.size());
        end else begin
            n_vec++; if (rq_s[0].sum !== 8'h00) begin n_err++; $display("FAIL small_wrap: got %h want 00", rq_s[0].sum); end
            n_vec++; if (rq_s[0].beats !== 2'd1) begin n_err++; $display("FAIL small_beats: got %0d want 1", rq_s[0].beats); end
            n_vec++; if (rq_s[0].cyc - t0 != 3) begin n_err++; $display("FAIL small_latency: got %0d want 3", rq_s[0].cyc - t0); end
        end
        rq_s.delete();
        beat_s(1'b1, 1'b0, 1'b1, 8'd1, 8'd1, 8'd1);
        for (int i = 0; i < 3; i++) beat_s(1'b0, 1'b0, 1'b1, 8'd1, 8'd1, 8'd1);
        beat_s(1'b0, 1'b1, 1'b1, 8'd1, 8'd1, 8'd1);
        idle_s();
        tick(6);
        n_vec++;
        if (rq_s.size() != 1) begin
            n_err++; $display("FAIL sat_count: got %0d results want 1", rq_s.size());
        end else begin
            n_vec++; if (rq_s[0].sum !== 8'd15) begin n_err++; $display("FAIL sat_sum: got %0d want 15", rq_s[0].sum); end
            n_vec++; if (rq_s[0].beats !== 2'd3) begin n_err++; $display("FAIL sat_beats: got %0d want 3", rq_s[0].beats); end
        end
    endtask

    initial begin
        test_reset();
        test_all_ones();
        test_back_to_back();
        test_accumulate();
        test_interleave();
        test_restart();
        test_reset_mid();
        test_small();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
